// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared types and constants for the boot-time instruction-memory loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : bytes packed into one instruction word
//   WORD_W         : instruction word width
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Packs accepted image bytes little-endian into 32-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear of lanes and byte counter (reload)
//   accept      : a byte is transferred this cycle
//   in_byte     : byte being transferred
//   in_last     : transferred byte is the final byte of the image
//   word_valid  : a complete (or zero-padded final) word is due this cycle
//   word        : the word that is due; upper unfilled lanes read as zero
// word_valid/word are combinational from the current accept so the parent
// can register them together with the write address in a single stage.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int LANE_W = WORD_W - 8;  // bytes held before the final lane

  logic [LANE_W-1:0] lanes_q, lanes_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;

  always_comb begin
    lanes_d    = lanes_q;
    byte_cnt_d = byte_cnt_q;
    word_valid = 1'b0;
    // Current byte placed in lane byte_cnt; lanes above it forced to zero
    // so a short final word is padded regardless of lane history.
    case (byte_cnt_q)
      2'd0:    word = {24'h000000, in_byte};
      2'd1:    word = {16'h0000, in_byte, lanes_q[7:0]};
      2'd2:    word = {8'h00, in_byte, lanes_q[15:0]};
      default: word = {in_byte, lanes_q[23:0]};
    endcase

    if (clear) begin
      lanes_d    = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      if (byte_cnt_q == 2'(BYTES_PER_WORD - 1) || in_last) begin
        word_valid = 1'b1;
        lanes_d    = '0;
        byte_cnt_d = '0;
      end else begin
        lanes_d    = word[LANE_W-1:0];
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a program image as a byte stream, writes it word by word into the
// CPU instruction memory, then releases the CPU via start.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : byte handshake; a byte transfers on a rising edge where
//                       both are high. in_byte/in_last are only meaningful
//                       while in_valid is high; in_valid with in_ready low is
//                       ignored and the byte must be held by the source.
//   in_byte, in_last  : image byte, final-byte marker
//   reload            : one-cycle request to load a new image (RUN only)
//   imem_we/addr/wdata: instruction-memory write port
//   start             : CPU run enable
//   load_done         : image fully written (WAIT and RUN)
//   word_count        : words written by the current load
//   err_overflow      : sticky, image larger than MEM_DEPTH words
// All outputs are registered.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int START_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              start,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow
);

  localparam int              DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [DLY_W-1:0] DLY_LAST = (START_DELAY > 0) ? DLY_W'(START_DELAY - 1) : '0;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;  // also the write pointer
  logic [DLY_W-1:0]    delay_q, delay_d;
  logic                err_q, err_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                in_ready_q, start_q, load_done_q;

  logic                accept;
  logic                pack_clear;
  logic                word_valid;
  logic [WORD_W-1:0]   word;

  assign accept = in_valid && in_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .accept     (accept),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    delay_d      = delay_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pack_clear   = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (word_valid) begin
          if (word_count_q == DEPTH_L) begin
            // Memory is full: drop the word and latch the error for good.
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = word;
            word_count_d = word_count_q + 1'b1;
            if (in_last) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // The final write occupies this cycle; a zero delay skips WAIT so
        // start follows the final write by exactly one cycle.
        delay_d = '0;
        state_d = (START_DELAY == 0) ? ST_RUN : ST_WAIT;
      end
      ST_WAIT: begin
        if (delay_q == DLY_LAST) state_d = ST_RUN;
        else                     delay_d = delay_q + 1'b1;
      end
      ST_RUN: begin
        if (reload) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
          pack_clear   = 1'b1;
        end
      end
      default: state_d = ST_ERR;  // ERR is left only through rst_n
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      word_count_q <= '0;
      delay_q      <= '0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      in_ready_q   <= 1'b0;
      start_q      <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      delay_q      <= delay_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      // Status outputs are decoded from the next state so they line up with
      // the state they describe without a combinational output path.
      in_ready_q   <= (state_d == ST_LOAD);
      start_q      <= (state_d == ST_RUN);
      load_done_q  <= (state_d == ST_WAIT) || (state_d == ST_RUN);
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign start        = start_q;
  assign load_done    = load_done_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_q;

endmodule
